led_div_ctrl: RTL and testbench

Button-driven divisor controller that feeds the LED blink counter. Two raw push-buttons (up/down) are synchronized and debounced. Each accepted press steps a registered 5-bit blink divisor within [1, DIV_MAX]. A single-cycle write strobe accompanies every change so the downstream counter restarts its phase immediately.

---
 rtl/led_pkg.sv | 23 ++
 rtl/led_div_ctrl_debounce.sv | 169 ++++++++++++++++
 rtl/led_div_ctrl.sv | 84 ++++++++
 tb/tb_led_div_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and limits for the LED blink-divisor controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_pkg;

  // Divisor register width and the largest divisor the blink counter honours.
  localparam int DIV_W     = 5;
  localparam int DIV_LIMIT = 20;

  // Debouncer states.
  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } deb_state_e;

  // Counter width for a cycle count; never below 1 bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_div_ctrl_debounce.sv
// Synchronizes and debounces one raw push-button; optional auto-repeat via LED_DIV_AUTOREPEAT_EN.
// Latency: press_o pulses 2 + DEBOUNCE_CYC edges after a clean raw rising edge.
// Backpressure: none; press_o is a one-cycle event the consumer must take.
module btn_debounce
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int REPEAT_CYC   = 50_000_000
) (
  input  logic clk100,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int              DCW      = cnt_w(DEBOUNCE_CYC);
  localparam logic [DCW-1:0]  DEB_LAST = DCW'(DEBOUNCE_CYC - 1);

  // Parameter sanity: a single-cycle debounce would make the WAIT states meaningless.
  if (DEBOUNCE_CYC < 2) begin : g_chk_deb
    $error("btn_debounce: DEBOUNCE_CYC must be >= 2");
  end
  if (REPEAT_CYC < 2) begin : g_chk_rpt
    $error("btn_debounce: REPEAT_CYC must be >= 2");
  end

  logic [1:0]     sync_q;
  logic           synced;
  deb_state_e     state_q;
  logic [DCW-1:0] cnt_q;
  logic [DCW-1:0] cnt_inc;
  logic           press_q;

  assign synced  = sync_q[1];
  assign cnt_inc = cnt_q + 1'b1;
  assign press_o = press_q;

  // Two-flop synchronizer for the asynchronous raw button.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

`ifdef LED_DIV_AUTOREPEAT_EN
  localparam int             RCW      = cnt_w(REPEAT_CYC);
  localparam logic [RCW-1:0] RPT_LAST = RCW'(REPEAT_CYC - 1);

  logic [RCW-1:0] rpt_q;

  // Debounce FSM with a repeat counter that only runs while PRESSED.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      rpt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      case (state_q)
        RELEASED: begin
          rpt_q <= '0;
          if (synced) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          rpt_q <= '0;
          if (!synced) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
          end else if (cnt_inc == DEB_LAST) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        PRESSED: begin
          if (!synced) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
            rpt_q   <= '0;
          end else if (rpt_q == RPT_LAST) begin
            rpt_q   <= '0;
            press_q <= 1'b1;
          end else begin
            rpt_q <= rpt_q + 1'b1;
          end
        end
        RELEASE_WAIT: begin
          rpt_q <= '0;
          if (synced) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_inc == DEB_LAST) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= RELEASED;
          cnt_q   <= '0;
          rpt_q   <= '0;
        end
      endcase
    end
  end
`else
  // Debounce FSM: one press event per accepted press, nothing on release.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      case (state_q)
        RELEASED: begin
          if (synced) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!synced) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
          end else if (cnt_inc == DEB_LAST) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        PRESSED: begin
          if (!synced) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (synced) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_inc == DEB_LAST) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= RELEASED;
          cnt_q   <= '0;
        end
      endcase
    end
  end
`endif

endmodule

// File: rtl/led_div_ctrl.sv
// Saturating blink-divisor register stepped by debounced up/down buttons (LED_DIV_AUTOREPEAT_EN adds hold-to-repeat).
// Latency: div_o/wren_o update 2 + DEBOUNCE_CYC + 1 edges after a clean raw button edge.
// Backpressure: none; wren_o is a one-cycle strobe the blink counter must honour.
module led_div_ctrl
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int REPEAT_CYC   = 50_000_000,
  parameter int DIV_MAX      = 20,
  parameter int DIV_RST      = 1
) (
  input  logic             clk100,
  input  logic             rst,
  input  logic             btn_up_i,
  input  logic             btn_dn_i,
  output logic [DIV_W-1:0] div_o,
  output logic             wren_o
);

  localparam logic [DIV_W-1:0] DIV_MAX_V = DIV_W'(DIV_MAX);
  localparam logic [DIV_W-1:0] DIV_MIN_V = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RST);

  // Parameter sanity: the divisor must stay inside what the blink counter accepts.
  if (DIV_MAX > DIV_LIMIT) begin : g_chk_max
    $error("led_div_ctrl: DIV_MAX exceeds DIV_LIMIT");
  end
  if (DIV_RST < 1 || DIV_MAX < DIV_RST) begin : g_chk_rst
    $error("led_div_ctrl: DIV_RST must lie in [1, DIV_MAX]");
  end

  logic             up_evt;
  logic             dn_evt;
  logic [DIV_W-1:0] div_q, div_d;
  logic             wren_q, wren_d;

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .REPEAT_CYC   (REPEAT_CYC)
  ) u_deb_up (
    .clk100  (clk100),
    .rst     (rst),
    .btn_i   (btn_up_i),
    .press_o (up_evt)
  );

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .REPEAT_CYC   (REPEAT_CYC)
  ) u_deb_dn (
    .clk100  (clk100),
    .rst     (rst),
    .btn_i   (btn_dn_i),
    .press_o (dn_evt)
  );

  // Next divisor: step once per lone event, hold at the limits, ignore simultaneous up+down.
  always_comb begin
    div_d  = div_q;
    wren_d = 1'b0;
    if (up_evt && !dn_evt && (div_q < DIV_MAX_V)) begin
      div_d  = div_q + 1'b1;
      wren_d = 1'b1;
    end else if (dn_evt && !up_evt && (div_q > DIV_MIN_V)) begin
      div_d  = div_q - 1'b1;
      wren_d = 1'b1;
    end
  end

  // Divisor register and its write strobe, updated together.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      div_q  <= DIV_RST_V;
      wren_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      wren_q <= wren_d;
    end
  end

  assign div_o  = div_q;
  assign wren_o = wren_q;

endmodule

// File: tb/tb_led_div_ctrl.sv
// Bench for led_div_ctrl with DEBOUNCE_CYC=8, REPEAT_CYC=32, DIV_MAX=20, DIV_RST=1.
// Expected strobes are queued when a press is driven and checked against wren_o/div_o.
// Define LED_DIV_AUTOREPEAT_EN for both bench and RTL to include the hold-to-repeat case.
module tb_led_div_ctrl;

  localparam int DEB  = 8;
  localparam int RPT  = 32;
  localparam int DMAX = 20;
  localparam int DRST = 1;
  localparam int LAT  = 2 + DEB + 1;

  logic       clk100 = 1'b0;
  logic       rst    = 1'b1;
  logic       btn_up_i = 1'b0;
  logic       btn_dn_i = 1'b0;
  logic [4:0] div_o;
  logic       wren_o;

  led_div_ctrl #(
    .DEBOUNCE_CYC (DEB),
    .REPEAT_CYC   (RPT),
    .DIV_MAX      (DMAX),
    .DIV_RST      (DRST)
  ) dut (
    .clk100   (clk100),
    .rst      (rst),
    .btn_up_i (btn_up_i),
    .btn_dn_i (btn_dn_i),
    .div_o    (div_o),
    .wren_o   (wren_o)
  );

  always #5 clk100 = ~clk100;

  int cyc = 0;
  always @(posedge clk100) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int div;
  } exp_t;

  typedef struct {
    logic up;
    logic dn;
    int   exp_div;
    logic exp_wr;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[51];
  int   nvec  = 0;
  int   nfail = 0;
  int   model_div = DRST;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    nvec++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  task automatic push_exp(input int at_cyc, input int d);
    exp_t e;
    e.cyc = at_cyc;
    e.div = d;
    sb.push_back(e);
  endtask

  // Press (u,d) for hold cycles starting right after a clock edge, then release and let it settle.
  task automatic do_press(input logic u, input logic d, input int hold,
                          input logic expw, input int expd);
    @(posedge clk100);
    #1;
    btn_up_i = u;
    btn_dn_i = d;
    if (expw) push_exp(cyc + LAT, expd);
    repeat (hold) @(posedge clk100);
    #1;
    btn_up_i = 1'b0;
    btn_dn_i = 1'b0;
    repeat (2 * DEB + 4) @(posedge clk100);
  endtask

  // Scoreboard monitor: every strobe must match the head of the queue in cycle and value.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk100);
      if (mon_en && !rst) begin
        if (wren_o) begin
          if (sb.size() == 0) begin
            chk("unexpected_strobe", int'(div_o), -1);
          end else begin
            e = sb.pop_front();
            chk("strobe_cycle", cyc, e.cyc);
            chk("strobe_div", int'(div_o), e.div);
            model_div = e.div;
          end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front();
          chk("missing_strobe_cycle", -1, e.cyc);
          model_div = e.div;
        end
        chk("div_hold", int'(div_o), model_div);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur;
    int s;

    // Table: 25 ups, 10 downs, one simultaneous up+down, 15 downs, starting from DIV_RST.
    cur = DRST;
    for (int i = 0; i < 51; i++) begin
      if (i < 25) begin
        tbl[i].up = 1'b1; tbl[i].dn = 1'b0;
        tbl[i].exp_wr = (cur < DMAX);
        if (cur < DMAX) cur = cur + 1;
      end else if (i == 35) begin
        tbl[i].up = 1'b1; tbl[i].dn = 1'b1;
        tbl[i].exp_wr = 1'b0;
      end else begin
        tbl[i].up = 1'b0; tbl[i].dn = 1'b1;
        tbl[i].exp_wr = (cur > 1);
        if (cur > 1) cur = cur - 1;
      end
      tbl[i].exp_div = cur;
    end

    fork
      monitor();
    join_none

    // Values held during reset.
    repeat (3) @(posedge clk100);
    #1;
    chk("rst_div", int'(div_o), DRST);
    chk("rst_wren", int'(wren_o), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Idle after reset: nothing moves for 100 cycles.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk100);
      chk("idle_div", int'(div_o), DRST);
      chk("idle_wren", int'(wren_o), 0);
    end

    // Table-driven presses: climb, saturate, descend, conflict, saturate.
    for (int i = 0; i < 51; i++) begin
      do_press(tbl[i].up, tbl[i].dn, 20, tbl[i].exp_wr, tbl[i].exp_div);
      chk("tbl_div", int'(div_o), tbl[i].exp_div);
    end

    // Clean up press held 20 cycles: single strobe, 1 -> 2.
    do_press(1'b1, 1'b0, 20, 1'b1, 2);
    chk("clean_div", int'(div_o), 2);

    // Bouncy press toggling at 0, 3, 5 then stable: one strobe timed from the last toggle.
    @(posedge clk100);
    #1;
    s = cyc;
    btn_up_i = 1'b1;
    push_exp(s + 5 + LAT, 3);
    repeat (3) @(posedge clk100);
    #1 btn_up_i = 1'b0;
    repeat (2) @(posedge clk100);
    #1 btn_up_i = 1'b1;
    repeat (20) @(posedge clk100);
    #1 btn_up_i = 1'b0;
    repeat (2 * DEB + 4) @(posedge clk100);
    chk("bounce_div", int'(div_o), 3);

    // Bursts one cycle short of the debounce window are ignored.
    do_press(1'b1, 1'b0, DEB - 1, 1'b0, 3);
    do_press(1'b0, 1'b1, DEB - 1, 1'b0, 3);
    chk("short_burst_div", int'(div_o), 3);

    // A burst of exactly the debounce window is accepted.
    do_press(1'b1, 1'b0, DEB, 1'b1, 4);
    chk("exact_burst_div", int'(div_o), 4);

    // Reset in the middle of PRESS_WAIT, button held through reset release.
    @(posedge clk100);
    #1 btn_up_i = 1'b1;
    repeat (5) @(posedge clk100);
    #3;
    rst = 1'b1;
    model_div = DRST;
    #1;
    chk("midrst_div", int'(div_o), DRST);
    chk("midrst_wren", int'(wren_o), 0);
    repeat (2) @(posedge clk100);
    #1;
    rst = 1'b0;
    s = cyc;
    push_exp(s + LAT, 2);
    repeat (20) @(posedge clk100);
    #1 btn_up_i = 1'b0;
    repeat (2 * DEB + 4) @(posedge clk100);
    chk("post_rst_div", int'(div_o), 2);

`ifdef LED_DIV_AUTOREPEAT_EN
    // Hold up for 190 cycles from DIV_RST: strobes at 11, 43, 75, 107, 139, 171.
    @(posedge clk100);
    #3;
    rst = 1'b1;
    model_div = DRST;
    @(posedge clk100);
    #1;
    rst = 1'b0;
    @(posedge clk100);
    #1;
    s = cyc;
    btn_up_i = 1'b1;
    for (int k = 0; k < 6; k++) push_exp(s + LAT + k * RPT, 2 + k);
    repeat (190) @(posedge clk100);
    #1 btn_up_i = 1'b0;
    repeat (2 * DEB + 4) @(posedge clk100);
    chk("repeat_div", int'(div_o), 7);
`endif

    repeat (5) @(posedge clk100);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
